// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 execution unit: format constants, flag
// bit positions, divider sizing and the divider FSM state encoding.
package fp16_pkg;

  localparam int unsigned BIAS         = 15;
  localparam int unsigned QBITS        = 12;  // 1 integer + 10 fraction + 1 guard
  localparam int unsigned MANT_W       = 11;  // mantissa with hidden bit
  localparam int unsigned REM_W        = 12;  // remainder after left shift needs one extra bit
  localparam int unsigned EXP_W        = 7;   // signed working exponent
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned EXP_NORM_MAX = 30;  // largest finite biased exponent

  localparam logic [4:0] EXP_MAX         = 5'h1F;
  localparam logic [9:0] CANON_QNAN_MANT = 10'h200;

  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fp16_classify.sv
// FP16 operand classifier (sign-independent).
// Ports: mag    - exponent and mantissa bits of an FP16 value
//        snan_c - signalling NaN        qnan_c - quiet NaN
//        inf_c  - infinity              zero_c - exact zero
//        sub_c  - subnormal
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [14:0] mag,
  output logic        snan_c,
  output logic        qnan_c,
  output logic        inf_c,
  output logic        zero_c,
  output logic        sub_c
);

  logic exp_all_ones;
  logic exp_all_zero;
  logic mant_zero;

  assign exp_all_ones = (mag[14:10] == EXP_MAX);
  assign exp_all_zero = (mag[14:10] == 5'h00);
  assign mant_zero    = (mag[9:0] == 10'h000);

  // Mantissa MSB distinguishes quiet from signalling NaN.
  assign snan_c = exp_all_ones && !mant_zero && !mag[9];
  assign qnan_c = exp_all_ones && !mant_zero &&  mag[9];
  assign inf_c  = exp_all_ones &&  mant_zero;
  assign zero_c = exp_all_zero &&  mant_zero;
  assign sub_c  = exp_all_zero && !mant_zero;

endmodule

// File: rtl/fp16_mant_divider.sv
// Restoring radix-2 mantissa divider, one quotient bit per clock.
// Ports: clk, reset - clock, async active-high reset
//        load       - capture ma/mb, clear quotient and count
//        step       - produce the next quotient bit
//        ma, mb     - 11-bit mantissas (hidden bit included)
//        q          - quotient, q[11] is the integer bit
//        last_c     - asserted during the final step
module fp16_mant_divider
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [MANT_W-1:0] ma,
  input  logic [MANT_W-1:0] mb,
  output logic [QBITS-1:0]  q,
  output logic              last_c
);

  logic [REM_W-1:0]  rem_q, rem_d;
  logic [MANT_W-1:0] mb_q, mb_d;
  logic [QBITS-1:0]  q_q, q_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rem_ge_c;
  logic [REM_W-1:0]  rem_sub_c;

  assign last_c = step && (cnt_q == CNT_W'(QBITS - 1));

  // Trial subtraction and next-state selection.
  always_comb begin
    rem_ge_c  = (rem_q >= REM_W'(mb_q));
    rem_sub_c = rem_ge_c ? (rem_q - REM_W'(mb_q)) : rem_q;
    rem_d     = rem_q;
    mb_d      = mb_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    if (load) begin
      rem_d = REM_W'(ma);
      mb_d  = mb;
      q_d   = '0;
      cnt_d = '0;
    end else if (step) begin
      q_d   = {q_q[QBITS-2:0], rem_ge_c};
      rem_d = rem_sub_c << 1;
      cnt_d = last_c ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      mb_q  <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      mb_q  <= mb_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fp16_div_seq.sv
// Multi-cycle truncating FP16 divider (quot = a / b), subnormals flushed to zero.
// Ports: clk, reset - clock, async active-high reset
//        start      - request, sampled only when idle
//        a, b       - dividend / divisor, captured on the accepted start edge
//        busy       - high whenever not idle
//        done       - one-cycle pulse, quot/flags valid from then on
//        quot       - result, held until the next done
//        flags      - {negative, carry(0), zero, overflow}
module fp16_div_seq
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic [3:0]  flags
);

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       quot_q, quot_d;
  logic [3:0]        flags_q, flags_d;

  logic a_snan_c, a_qnan_c, a_inf_c, a_zero_c, a_sub_c;
  logic b_snan_c, b_qnan_c, b_inf_c, b_zero_c, b_sub_c;
  logic a_zlike_c, b_zlike_c, sign_c;

  logic              div_load_c, div_step_c, div_last_c;
  logic [QBITS-1:0]  div_q;

  logic              spec_hit_c;
  logic [15:0]       spec_quot_c;
  logic [3:0]        spec_flags_c;

  logic [EXP_W-1:0]  norm_exp_c;
  logic [9:0]        norm_frac_c;
  logic [15:0]       norm_quot_c;
  logic [3:0]        norm_flags_c;

  fp16_classify u_cls_a (
    .mag    (a[14:0]),
    .snan_c (a_snan_c),
    .qnan_c (a_qnan_c),
    .inf_c  (a_inf_c),
    .zero_c (a_zero_c),
    .sub_c  (a_sub_c)
  );

  fp16_classify u_cls_b (
    .mag    (b[14:0]),
    .snan_c (b_snan_c),
    .qnan_c (b_qnan_c),
    .inf_c  (b_inf_c),
    .zero_c (b_zero_c),
    .sub_c  (b_sub_c)
  );

  fp16_mant_divider u_mdiv (
    .clk    (clk),
    .reset  (reset),
    .load   (div_load_c),
    .step   (div_step_c),
    .ma     ({1'b1, a[9:0]}),
    .mb     ({1'b1, b[9:0]}),
    .q      (div_q),
    .last_c (div_last_c)
  );

  // Subnormals are flushed, so they behave as zero operands.
  assign a_zlike_c = a_zero_c | a_sub_c;
  assign b_zlike_c = b_zero_c | b_sub_c;
  assign sign_c    = a[15] ^ b[15];

  // Special-operand resolution in priority order.
  always_comb begin
    spec_hit_c   = 1'b1;
    spec_quot_c  = '0;
    spec_flags_c = '0;
    if (a_snan_c) begin
      spec_quot_c = a;
    end else if (b_snan_c) begin
      spec_quot_c = b;
    end else if (a_qnan_c) begin
      spec_quot_c = a;
    end else if (b_qnan_c) begin
      spec_quot_c = b;
    end else if ((a_zlike_c && b_zlike_c) || (a_inf_c && b_inf_c)) begin
      spec_quot_c = {sign_c, EXP_MAX, CANON_QNAN_MANT};
    end else if (a_inf_c) begin
      spec_quot_c = {sign_c, EXP_MAX, 10'h000};
    end else if (b_zlike_c) begin
      spec_quot_c         = {sign_c, EXP_MAX, 10'h000};
      spec_flags_c[FLG_V] = 1'b1;
    end else if (a_zlike_c || b_inf_c) begin
      spec_quot_c         = {sign_c, 15'h0000};
      spec_flags_c[FLG_Z] = 1'b1;
    end else begin
      spec_hit_c = 1'b0;
    end
    spec_flags_c[FLG_C] = 1'b0;
    spec_flags_c[FLG_N] = spec_quot_c[15];
  end

  // Normalisation: quotient in (0.5, 2), so at most one left shift.
  always_comb begin
    norm_exp_c   = exp_q;
    norm_frac_c  = div_q[10:1];
    norm_flags_c = '0;
    if (!div_q[QBITS-1]) begin
      norm_frac_c = div_q[9:0];
      norm_exp_c  = exp_q - EXP_W'(1);
    end
    if ($signed(norm_exp_c) > $signed(EXP_W'(EXP_NORM_MAX))) begin
      norm_quot_c         = {sign_q, EXP_MAX, 10'h000};
      norm_flags_c[FLG_V] = 1'b1;
    end else if ($signed(norm_exp_c) < $signed(EXP_W'(1))) begin
      norm_quot_c         = {sign_q, 15'h0000};
      norm_flags_c[FLG_Z] = 1'b1;
    end else begin
      norm_quot_c = {sign_q, norm_exp_c[4:0], norm_frac_c};
    end
    norm_flags_c[FLG_N] = norm_quot_c[15];
  end

  // Next-state and output computation.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    quot_d     = quot_q;
    flags_d    = flags_q;
    div_load_c = 1'b0;
    div_step_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = sign_c;
          exp_d  = EXP_W'(a[14:10]) - EXP_W'(b[14:10]) + EXP_W'(BIAS);
          if (spec_hit_c) begin
            quot_d  = spec_quot_c;
            flags_d = spec_flags_c;
            state_d = DONE;
          end else begin
            div_load_c = 1'b1;
            state_d    = DIV;
          end
        end
      end
      DIV: begin
        div_step_c = 1'b1;
        if (div_last_c) state_d = NORM;
      end
      NORM: begin
        quot_d  = norm_quot_c;
        flags_d = norm_flags_c;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      flags_q <= flags_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign quot  = quot_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Self-checking bench for fp16_div_seq: an arithmetic reference model plus a
// latency countdown, compared against the DUT every cycle, and directed vectors
// with hand-computed results.
module tb_fp16_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] quot;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fp16_div_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .quot  (quot),
    .flags (flags)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result computed with integer arithmetic.
  task automatic ref_div(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] q, output logic [3:0] f, output bit special);
    int ea, eb, fa, fb, qq, e, frac;
    bit s, xnan, ynan, xinf, yinf, xz, yz;
    ea = int'(x[14:10]); eb = int'(y[14:10]);
    fa = int'(x[9:0]);   fb = int'(y[9:0]);
    s  = x[15] ^ y[15];
    xnan = (ea == 31) && (fa != 0);  ynan = (eb == 31) && (fb != 0);
    xinf = (ea == 31) && (fa == 0);  yinf = (eb == 31) && (fb == 0);
    xz = (ea == 0);                  yz = (eb == 0);
    f = 4'b0000;
    special = 1'b1;
    if (xnan && !x[9])               q = x;
    else if (ynan && !y[9])          q = y;
    else if (xnan)                   q = x;
    else if (ynan)                   q = y;
    else if ((xz && yz) || (xinf && yinf)) q = {s, 15'h7E00};
    else if (xinf)                   q = {s, 15'h7C00};
    else if (yz) begin               q = {s, 15'h7C00}; f[0] = 1'b1; end
    else if (xz || yinf) begin       q = {s, 15'h0000}; f[1] = 1'b1; end
    else begin
      special = 1'b0;
      qq = ((1024 + fa) * 2048) / (1024 + fb);   // 12-bit truncated quotient
      e  = ea - eb + 15;
      if (qq >= 2048) frac = (qq >> 1) & 1023;
      else begin frac = qq & 1023; e = e - 1; end
      if (e > 30) begin q = {s, 15'h7C00}; f[0] = 1'b1; end
      else if (e < 1) begin q = {s, 15'h0000}; f[1] = 1'b1; end
      else q = {s, 5'(e), 10'(frac)};
    end
    f[3] = q[15];
  endtask

  // Cycle model: m_left counts the busy cycles still to come.
  logic [15:0] m_quot;
  logic [3:0]  m_flags;
  logic        m_busy, m_done;
  int          m_left;

  always @(posedge clk or posedge reset) begin : model
    logic [15:0] pq;
    logic [3:0]  pf;
    bit          sp;
    int          nl;
    if (reset) begin
      m_left  <= 0;
      m_quot  <= 16'h0000;
      m_flags <= 4'h0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      nl = m_left;
      if (nl == 0) begin
        if (start) begin
          ref_div(a, b, pq, pf, sp);
          nl = sp ? 1 : 14;
          // Result is committed on the edge that enters the done cycle.
          if (sp) begin m_quot <= pq; m_flags <= pf; end
          else    begin m_quot <= m_quot; m_flags <= m_flags; end
        end
      end else begin
        nl = nl - 1;
      end
      if (nl == 1 && m_left == 2) begin
        ref_div(hold_a, hold_b, pq, pf, sp);
        m_quot  <= pq;
        m_flags <= pf;
      end
      m_done <= (nl == 1);
      m_busy <= (nl != 0);
      m_left <= nl;
    end
  end

  // Operands captured by the model when an operation is accepted.
  logic [15:0] hold_a, hold_b;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_a <= 16'h0000;
      hold_b <= 16'h0000;
    end else if (m_left == 0 && start) begin
      hold_a <= a;
      hold_b <= b;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy",  32'(busy),  32'(m_busy));
      check("cyc_done",  32'(done),  32'(m_done));
      check("cyc_quot",  32'(quot),  32'(m_quot));
      check("cyc_flags", 32'(flags), 32'(m_flags));
    end
  end

  // One operation: pin the model to the literal, then check the DUT result and latency.
  task automatic do_op(input string nm, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] eq, input logic [3:0] ef, input int eoff,
                       input bit poke);
    logic [15:0] mq;
    logic [3:0]  mf;
    bit          sp;
    int          off;
    ref_div(x, y, mq, mf, sp);
    check({nm, "_model_q"}, 32'(mq), 32'(eq));
    check({nm, "_model_f"}, 32'(mf), 32'(ef));
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    off = 0;
    while (!done && off < 40) begin
      if (poke && off == 3) begin
        a = 16'h4600; b = 16'h4000; start = 1'b1;
      end else if (poke && off == 4) begin
        start = 1'b0;
      end
      @(negedge clk);
      off++;
    end
    start = 1'b0;
    check({nm, "_lat"},   32'(off),   32'(eoff));
    check({nm, "_quot"},  32'(quot),  32'(eq));
    check({nm, "_flags"}, 32'(flags), 32'(ef));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int dcount;
    reset = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_quot",  32'(quot),  32'h0000);
    check("rst_flags", 32'(flags), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    do_op("div_6_2",     16'h4600, 16'h4000, 16'h4200, 4'b0000, 13, 1'b0);
    do_op("div_1_3",     16'h3C00, 16'h4200, 16'h3555, 4'b0000, 13, 1'b0);
    do_op("div_2_1p5",   16'h4000, 16'h3E00, 16'h3D55, 4'b0000, 13, 1'b0);
    do_op("div_m6_2",    16'hC600, 16'h4000, 16'hC200, 4'b1000, 13, 1'b0);
    do_op("div_m1_0",    16'hBC00, 16'h0000, 16'hFC00, 4'b1001, 0,  1'b0);
    do_op("div_0_0",     16'h0000, 16'h0000, 16'h7E00, 4'b0000, 0,  1'b0);
    do_op("div_snan",    16'h7D00, 16'h7E00, 16'h7D00, 4'b0000, 0,  1'b0);
    do_op("div_qnan_b",  16'h4000, 16'h7E01, 16'h7E01, 4'b0000, 0,  1'b0);
    do_op("div_inf_inf", 16'h7C00, 16'h7C00, 16'h7E00, 4'b0000, 0,  1'b0);
    do_op("div_inf_2",   16'h7C00, 16'h4000, 16'h7C00, 4'b0000, 0,  1'b0);
    do_op("div_1_inf",   16'h3C00, 16'h7C00, 16'h0000, 4'b0010, 0,  1'b0);
    do_op("div_ovf",     16'h7BFF, 16'h0400, 16'h7C00, 4'b0001, 13, 1'b0);
    do_op("div_unf",     16'h0400, 16'h7BFF, 16'h0000, 4'b0010, 13, 1'b0);
    do_op("div_3c_poke", 16'h3C00, 16'h4200, 16'h3555, 4'b0000, 13, 1'b1);

    // Abort in the fifth DIV cycle.
    @(negedge clk);
    a = 16'h4600; b = 16'h4000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_quot",  32'(quot),  32'h0000);
    check("abort_flags", 32'(flags), 32'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);

    do_op("after_abort", 16'h4600, 16'h4000, 16'h4200, 4'b0000, 13, 1'b0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
